// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the canonical nop encoding and the boot PC.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_ISSUE,
        HOLD,
        DISCARD
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response and decode handshake bundle for the fetch stage.
interface fetch_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);

    logic                     imem_req;
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic                     imem_rvalid;
    logic [DATA_WIDTH-1:0]    imem_rdata;

    logic                     id_valid;
    logic                     id_ready;
    logic [DATA_WIDTH-1:0]    id_instr;
    logic [ADDRESS_WIDTH-1:0] id_pc;
    logic [ADDRESS_WIDTH-1:0] id_pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        output id_valid, id_instr, id_pc, id_pc_plus4,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        input  id_valid, id_instr, id_pc, id_pc_plus4,
        output id_ready
    );

endinterface

// File: rtl/pc_next.sv
// Next-PC selection: sequential pc+4 or a redirect target forced to word alignment.
module pc_next #(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic [ADDRESS_WIDTH-1:0] next_pc,
    output logic                     misalign
);

    always_comb begin
        next_pc  = pc + ADDRESS_WIDTH'(4);
        misalign = 1'b0;
        if (redirect_valid) begin
            next_pc  = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
            misalign = |redirect_target[1:0];
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues one outstanding imem read at a time
// and buffers the returned word for decode, squashing wrong-path responses on redirect.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fetch_stage_if.master            bus,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic                     misalign_err
);

    fetch_state_t             state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ADDRESS_WIDTH-1:0] next_pc;
    logic                     misalign;
    logic [DATA_WIDTH-1:0]    instr_q;
    logic [ADDRESS_WIDTH-1:0] instr_pc_q;
    logic                     req_q;
    logic                     valid_q;

    pc_next #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_pc_next (
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .next_pc        (next_pc),
        .misalign       (misalign)
    );

    // A redirect always wins; in DISCARD the stale response is only used as the
    // signal that the memory is free again, never as data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FETCH_ISSUE;
            pc           <= RESET_PC;
            addr_q       <= RESET_PC;
            instr_q      <= DATA_WIDTH'(NOP_INSTR);
            instr_pc_q   <= RESET_PC;
            misalign_err <= 1'b0;
            req_q        <= 1'b1;
            valid_q      <= 1'b0;
        end else begin
            if (misalign) begin
                misalign_err <= 1'b1;
            end
            case (state)
                FETCH_ISSUE: begin
                    if (redirect_valid) begin
                        pc <= next_pc;
                        if (bus.imem_rvalid) begin
                            addr_q <= next_pc;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (bus.imem_rvalid) begin
                        instr_q    <= bus.imem_rdata;
                        instr_pc_q <= addr_q;
                        state      <= HOLD;
                        req_q      <= 1'b0;
                        valid_q    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid || bus.id_ready) begin
                        pc      <= next_pc;
                        addr_q  <= next_pc;
                        state   <= FETCH_ISSUE;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                DISCARD: begin
                    if (redirect_valid) begin
                        pc <= next_pc;
                    end
                    if (bus.imem_rvalid) begin
                        addr_q <= redirect_valid ? next_pc : pc;
                        state  <= FETCH_ISSUE;
                    end
                end
                default: begin
                    state   <= FETCH_ISSUE;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Gating with rst_n keeps both handshakes quiet for the whole reset cycle.
    assign bus.imem_req    = req_q && rst_n;
    assign bus.imem_addr   = addr_q;
    assign bus.id_valid    = valid_q && rst_n;
    assign bus.id_instr    = instr_q;
    assign bus.id_pc       = instr_pc_q;
    assign bus.id_pc_plus4 = instr_pc_q + ADDRESS_WIDTH'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable instruction memory model
// and hand-computed expectations for each cycle of interest.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misalign_err;

    int latency = 0;
    int waitCnt = 0;
    int testsRun = 0;
    int testsFailed = 0;

    fetch_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1234_0013);
    endfunction

    // Memory answers once the request has been pending for 'latency' edges.
    assign bus.imem_rvalid = bus.imem_req && (waitCnt >= latency);
    assign bus.imem_rdata  = memWord(bus.imem_addr);

    always @(posedge clk) begin
        if (!bus.imem_req || bus.imem_rvalid) waitCnt <= 0;
        else waitCnt <= waitCnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rt, input logic rdy);
        @(posedge clk);
        #1;
        redirect_valid  = rv;
        redirect_target = rt;
        bus.id_ready    = rdy;
    endtask

    initial begin
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        bus.id_ready    = 1'b1;

        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("reset_req", {31'h0, bus.imem_req}, 32'h0);
        checkOutput("reset_valid", {31'h0, bus.id_valid}, 32'h0);
        checkOutput("reset_instr", bus.id_instr, 32'h0000_0013);
        checkOutput("reset_pc", bus.id_pc, 32'h0);
        checkOutput("reset_misalign", {31'h0, misalign_err}, 32'h0);

        applyStimulus(1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("c1_req", {31'h0, bus.imem_req}, 32'h1);
        checkOutput("c1_addr", bus.imem_addr, 32'h0);
        checkOutput("c1_valid", {31'h0, bus.id_valid}, 32'h0);

        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("c2_valid", {31'h0, bus.id_valid}, 32'h1);
        checkOutput("c2_instr", bus.id_instr, 32'h0050_0093);
        checkOutput("c2_pc", bus.id_pc, 32'h0);
        checkOutput("c2_pc_plus4", bus.id_pc_plus4, 32'h4);
        checkOutput("c2_req", {31'h0, bus.imem_req}, 32'h0);

        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("c3_addr", bus.imem_addr, 32'h4);
        checkOutput("c3_req", {31'h0, bus.imem_req}, 32'h1);

        // Back-pressure: word at 4 sits in HOLD for five cycles.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            @(negedge clk);
            checkOutput("bp_valid", {31'h0, bus.id_valid}, 32'h1);
            checkOutput("bp_instr", bus.id_instr, 32'h1234_0017);
            checkOutput("bp_pc", bus.id_pc, 32'h4);
            checkOutput("bp_req", {31'h0, bus.imem_req}, 32'h0);
        end

        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        latency = 3;
        @(negedge clk);
        checkOutput("bp_next_addr", bus.imem_addr, 32'h8);
        checkOutput("bp_next_req", {31'h0, bus.imem_req}, 32'h1);

        // Redirect while the slow request at 8 is still outstanding.
        applyStimulus(1'b1, 32'h40, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("disc_addr_hold", bus.imem_addr, 32'h8);
        checkOutput("disc_req", {31'h0, bus.imem_req}, 32'h1);
        checkOutput("disc_valid", {31'h0, bus.id_valid}, 32'h0);

        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("disc_stale_valid", {31'h0, bus.id_valid}, 32'h0);
        checkOutput("disc_stale_addr", bus.imem_addr, 32'h8);

        applyStimulus(1'b0, 32'h0, 1'b1);
        latency = 0;
        @(negedge clk);
        checkOutput("disc_new_addr", bus.imem_addr, 32'h40);
        checkOutput("disc_new_valid", {31'h0, bus.id_valid}, 32'h0);

        // Redirect in HOLD with id_ready also high.
        applyStimulus(1'b1, 32'h100, 1'b1);
        @(negedge clk);
        checkOutput("hold_valid", {31'h0, bus.id_valid}, 32'h1);
        checkOutput("hold_pc", bus.id_pc, 32'h40);
        checkOutput("hold_instr", bus.id_instr, 32'h1234_0053);

        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("hold_redir_valid", {31'h0, bus.id_valid}, 32'h0);
        checkOutput("hold_redir_addr", bus.imem_addr, 32'h100);

        // Misaligned redirect.
        applyStimulus(1'b1, 32'h103, 1'b1);
        @(negedge clk);
        checkOutput("pre_misalign", {31'h0, misalign_err}, 32'h0);
        checkOutput("pre_misalign_pc", bus.id_pc, 32'h100);

        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("misalign_addr", bus.imem_addr, 32'h100);
        checkOutput("misalign_err", {31'h0, misalign_err}, 32'h1);

        // Wrap-around at the top of the address space.
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);

        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("wrap_pc", bus.id_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pc_plus4", bus.id_pc_plus4, 32'h0);
        checkOutput("wrap_instr", bus.id_instr, 32'hEDCB_FFEF);

        applyStimulus(1'b1, 32'h200, 1'b1);
        latency = 3;
        @(negedge clk);
        checkOutput("wrap_next_addr", bus.imem_addr, 32'h0);
        checkOutput("misalign_sticky", {31'h0, misalign_err}, 32'h1);

        // Two redirects during DISCARD: the later one must win.
        applyStimulus(1'b1, 32'h300, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("multi_addr_hold", bus.imem_addr, 32'h0);
        checkOutput("multi_req", {31'h0, bus.imem_req}, 32'h1);

        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h400, 1'b1);
        @(negedge clk);
        checkOutput("multi_last_wins", bus.imem_addr, 32'h300);

        // Reset while in DISCARD.
        applyStimulus(1'b0, 32'h0, 1'b1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("rst_mid_req", {31'h0, bus.imem_req}, 32'h0);
        checkOutput("rst_mid_valid", {31'h0, bus.id_valid}, 32'h0);
        checkOutput("rst_mid_misalign", {31'h0, misalign_err}, 32'h0);

        applyStimulus(1'b0, 32'h0, 1'b1);
        rst_n   = 1'b1;
        latency = 0;
        @(negedge clk);
        checkOutput("rst_after_addr", bus.imem_addr, 32'h0);
        checkOutput("rst_after_req", {31'h0, bus.imem_req}, 32'h1);

        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("rst_after_valid", {31'h0, bus.id_valid}, 32'h1);
        checkOutput("rst_after_instr", bus.id_instr, 32'h0050_0093);
        checkOutput("rst_after_pc", bus.id_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end of the CPU. Owns the PC register and issues single-outstanding read requests to instruction memory.
- Buffers each returned instruction and presents it with its PC to decode through a valid/ready handshake. Decode slices op/funct3/funct7 from id_instr for the control unit.
- Accepts PC redirects from the control path (taken branch, jal, jalr) and squashes wrong-path instructions.

Parameters:
- ADDRESS_WIDTH, 32, PC and memory address width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- imem_req  out  1  read request; held high until imem_rvalid.
- imem_addr  out  ADDRESS_WIDTH  request address; stable while imem_req is high.
- imem_rvalid  in  1  response valid; at most one per request; may arrive the cycle after imem_req rises, or later.
- imem_rdata  in  DATA_WIDTH  instruction word; valid with imem_rvalid.
- redirect_valid  in  1  PC redirect (PCSrc) this cycle.
- redirect_target  in  ADDRESS_WIDTH  redirect destination.
- id_valid  out  1  buffered instruction available.
- id_ready  in  1  decode accepts the instruction.
- id_instr  out  DATA_WIDTH  buffered instruction.
- id_pc  out  ADDRESS_WIDTH  PC of id_instr.
- id_pc_plus4  out  ADDRESS_WIDTH  id_pc+4; link value for jal/jalr.
- misalign_err  out  1  sticky flag: a redirect target had bits[1:0] != 0.

Behaviour:
- Reset (rst_n low at clk edge):
  - pc=RESET_PC, addr_q=RESET_PC, state=FETCH_ISSUE.
  - id_instr=32'h0000_0013 (nop), id_pc=RESET_PC, misalign_err=0.
  - imem_req=0 and id_valid=0 during the reset cycle.
- FSM states:
  - FETCH_ISSUE: imem_req=1, imem_addr=addr_q.
  - HOLD: id_valid=1; imem_req=0.
  - DISCARD: imem_req=1; waits for the stale response.
- Transitions, with redirect_valid taking priority over everything else:
  - FETCH_ISSUE, rvalid=1, no redirect: latch id_instr=imem_rdata, id_pc=addr_q; go to HOLD.
  - FETCH_ISSUE, redirect, rvalid=0: pc=target; go to DISCARD.
  - FETCH_ISSUE, redirect, rvalid=1: drop the response; pc=addr_q=target; stay in FETCH_ISSUE.
  - HOLD, id_ready=1, no redirect: pc=addr_q=pc+4; go to FETCH_ISSUE.
  - HOLD, id_ready=0: hold all outputs stable.
  - HOLD, redirect (regardless of id_ready): id_valid drops next cycle, buffered instruction is dropped; pc=addr_q=target; go to FETCH_ISSUE.
  - DISCARD, rvalid=1: drop the response; addr_q=pc; go to FETCH_ISSUE.
  - DISCARD, further redirect: pc=latest target; stay in DISCARD until rvalid. The last redirect wins.
- Latency and throughput:
  - Minimum 2 cycles per instruction (issue, then hold).
  - With zero-wait memory and id_ready tied high, id_valid pulses every other cycle.
- Address handling:
  - imem_addr never changes while imem_req=1 and rvalid has not arrived.
  - PC arithmetic is modulo 2^ADDRESS_WIDTH: 32'hFFFF_FFFC+4 wraps to 0.
- Misaligned redirect: target bits[1:0] are forced to 00 before loading pc, and misalign_err is set. misalign_err clears only on reset.
- Reset mid-operation: any outstanding response arriving after reset is ignored. The first request after reset uses RESET_PC.
- id_pc_plus4 is combinational from id_pc.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {FETCH_ISSUE, HOLD, DISCARD}.
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default.
- Sub-module pc_next (combinational):
  - Selects pc+4 vs. redirect target.
  - Applies the alignment mask and raises the misalign indication.
- FSM, buffer registers and handshake stay in fetch_stage.

Test Plan:
- Reset release, zero-wait memory returning 0x00500093 at addr 0, id_ready=1:
  - imem_addr=0 in cycle 1; id_valid=1 with id_instr=0x00500093 and id_pc=0 in cycle 2; imem_addr=4 in cycle 3.
- Back-pressure: id_ready=0 for 5 cycles while in HOLD:
  - id_valid, id_instr and id_pc stay constant and imem_req=0.
  - After id_ready=1, the next request goes to id_pc+4.
- Redirect while response is outstanding: memory latency 3, redirect to 0x40 in the cycle after issue:
  - State goes to DISCARD and imem_addr holds its old value.
  - The stale response is dropped with no id_valid.
  - The next request uses addr 0x40.
- Redirect in HOLD with id_ready=1 in the same cycle, target 0x100:
  - The instruction is not advanced past.
  - id_valid drops next cycle and the next imem_addr is 0x100.
- Misaligned redirect to 0x103:
  - Next fetch address is 0x100 and misalign_err=1.
  - misalign_err stays set until rst_n=0.
- Wrap-around:
  - Redirect to 0xFFFF_FFFC, accept the instruction; next imem_addr is 0x0000_0000.
  - Assert rst_n=0 mid-DISCARD: the following fetch goes to RESET_PC.
